// File: rtl/digi_logic_pkg.sv
// Shared types and helpers for the digital-logic block family.
// Used by the bit scanner and the arbiters built on prio_enc.
package digi_logic_pkg;

    typedef enum logic {
        IDLE,
        SCAN
    } scan_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_bit_scanner_if.sv
// Input/output handshake bundle for prio_bit_scanner.
// slave is the scanner side, master the producer/consumer side.
interface prio_bit_scanner_if
    import digi_logic_pkg::*;
#(
    parameter int WIDTH = 16
);
    localparam int IDX_W = clog2_min1(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_empty;
    logic [IDX_W:0]   out_count;

    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_idx,
        output out_last,
        output out_empty,
        output out_count
    );

    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_idx,
        input  out_last,
        input  out_empty,
        input  out_count
    );

endinterface

// File: rtl/prio_enc.sv
// Combinational priority encoder, MSB- or LSB-first.
// idx is 0 when no bit is set.
module prio_enc
    import digi_logic_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1,
    localparam int IDX_W    = clog2_min1(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Last match in scan order wins, so iterate towards the priority end.
    always_comb begin
        idx = '0;
        any = 1'b0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) begin
                    idx = IDX_W'(i);
                    any = 1'b1;
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    idx = IDX_W'(i);
                    any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prio_bit_scanner.sv
// Streams the index of every set bit of an accepted vector,
// one beat per output handshake, in priority order.
module prio_bit_scanner
    import digi_logic_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1,
    localparam int IDX_W    = clog2_min1(WIDTH)
) (
    input logic          clk,
    input logic          rst,
    prio_bit_scanner_if.slave bus
);

    scan_state_e      state;
    logic [WIDTH-1:0] rem;
    logic [IDX_W:0]   cnt;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             scan;
    logic             one_left;
    logic             xfer;

    prio_enc #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_enc (
        .vec (rem),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign scan     = (state == SCAN);
    // Clearing the lowest set bit leaves zero iff at most one bit was set.
    assign one_left = ((rem & (rem - WIDTH'(1))) == '0);
    assign xfer     = scan && bus.out_ready;

    assign bus.in_ready  = !scan;
    assign bus.out_valid = scan;
    assign bus.out_idx   = scan ? enc_idx : '0;
    assign bus.out_last  = scan && one_left;
    assign bus.out_empty = scan && !enc_any;
    assign bus.out_count = scan ? cnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        rem   <= bus.in_vec;
                        cnt   <= (IDX_W + 1)'(1);
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (xfer) begin
                        if (one_left) begin
                            state <= IDLE;
                        end else begin
                            rem <= rem & ~(WIDTH'(1) << enc_idx);
                            cnt <= cnt + (IDX_W + 1)'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_bit_scanner.sv
// Directed scoreboard bench for prio_bit_scanner, one MSB-first
// and one LSB-first instance sharing clock and reset.
module tb_prio_bit_scanner;
    import digi_logic_pkg::*;

    typedef struct {
        int idx;
        bit last;
        bit empty;
        int cnt;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_vec = '0;
    logic        out_ready = 1'b0;
    bit          hold_rand = 1'b0;

    int tests = 0;
    int fails = 0;
    beat_t q[$];

    always #5 clk = ~clk;

    prio_bit_scanner_if #(.WIDTH(16)) bm ();
    prio_bit_scanner_if #(.WIDTH(16)) bl ();

    assign bm.in_valid  = !sel && in_valid;
    assign bm.in_vec    = in_vec;
    assign bm.out_ready = !sel && out_ready;
    assign bl.in_valid  = sel && in_valid;
    assign bl.in_vec    = in_vec;
    assign bl.out_ready = sel && out_ready;

    prio_bit_scanner #(
        .WIDTH     (16),
        .MSB_FIRST (1'b1)
    ) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bm.slave)
    );

    prio_bit_scanner #(
        .WIDTH     (16),
        .MSB_FIRST (1'b0)
    ) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bl.slave)
    );

    wire       c_in_ready = sel ? bl.in_ready  : bm.in_ready;
    wire       c_valid    = sel ? bl.out_valid : bm.out_valid;
    wire [3:0] c_idx      = sel ? bl.out_idx   : bm.out_idx;
    wire       c_last     = sel ? bl.out_last  : bm.out_last;
    wire       c_empty    = sel ? bl.out_empty : bm.out_empty;
    wire [4:0] c_count    = sel ? bl.out_count : bm.out_count;

    task automatic check(input string tag,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void model(input logic [15:0] v, input bit msb);
        int n;
        int c;
        int i;
        n = $countones(v);
        c = 0;
        if (v == 16'h0000) begin
            q.push_back('{0, 1'b1, 1'b1, 1});
        end else begin
            for (int j = 0; j < 16; j++) begin
                i = msb ? 15 - j : j;
                if (v[i]) begin
                    c++;
                    q.push_back('{i, c == n, 1'b0, c});
                end
            end
        end
    endfunction

    task automatic send(input logic [15:0] v);
        @(negedge clk);
        check("in_ready_idle", c_in_ready, 1);
        check("out_valid_idle", c_valid, 0);
        in_valid = 1'b1;
        in_vec   = v;
        model(v, !sel);
        @(negedge clk);
        if (!hold_rand) in_valid = 1'b0;
        check("first_valid_latency", c_valid, 1);
    endtask

    task automatic check_beat(input string tag);
        check({tag, "_valid"}, c_valid, 1);
        check({tag, "_idx"},   c_idx,   q[0].idx);
        check({tag, "_last"},  c_last,  q[0].last);
        check({tag, "_empty"}, c_empty, q[0].empty);
        check({tag, "_count"}, c_count, q[0].cnt);
    endtask

    task automatic drain(input bit toggle);
        int k;
        bit done;
        k = 0;
        done = 1'b0;
        while (!done && k < 64) begin
            out_ready = toggle ? (k % 2 == 0) : 1'b1;
            if (hold_rand) in_vec = 16'($urandom);
            if (q.size() == 0) break;
            check_beat(out_ready ? "beat" : "stall");
            if (out_ready) begin
                done = q[0].last;
                void'(q.pop_front());
            end
            @(negedge clk);
            k++;
        end
        out_ready = 1'b0;
        check("drain_done", done, 1);
        check("in_ready_after_last", c_in_ready, 1);
        check("out_valid_after_last", c_valid, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_ready", c_in_ready, 1);
        check("rst_out_valid", c_valid, 0);
        check("rst_out_idx", c_idx, 0);
        check("rst_out_last", c_last, 0);
        check("rst_out_empty", c_empty, 0);
        check("rst_out_count", c_count, 0);
        rst = 1'b0;

        sel = 1'b0;
        send(16'h8001);
        drain(1'b0);

        send(16'h0000);
        drain(1'b0);

        send(16'hFFFF);
        drain(1'b1);

        sel = 1'b1;
        send(16'h0128);
        drain(1'b0);

        sel = 1'b0;
        send(16'h00F0);
        out_ready = 1'b1;
        check_beat("pre_rst");
        void'(q.pop_front());
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        check("midscan_rst_valid", c_valid, 0);
        check("midscan_rst_ready", c_in_ready, 1);
        check("midscan_rst_count", c_count, 0);
        q.delete();
        send(16'h0002);
        drain(1'b0);

        hold_rand = 1'b1;
        send(16'h0030);
        drain(1'b0);
        in_valid  = 1'b0;
        hold_rand = 1'b0;
        @(negedge clk);
        check("hold_single_accept", c_valid, 0);
        check("scoreboard_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
